square_num: RTL and testbench

//   Sequential shift-and-add squarer: the inverse of the square-root block. It accepts an

---
 rtl/square_num.sv | 123 ++++++++++++
 tb/tb_square_num.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/square_num.sv
// square_num: sequential shift-and-add squarer.
//
// Squares an unsigned WIDTH-bit root into a 2*WIDTH-bit result, one
// partial product per cycle, exactly WIDTH iterations per operation.
// Only one operation is in flight at a time.
//
// Handshake semantics (both sides): a transfer happens on a rising CLK
// edge where valid and ready are both high. The producer holds its data
// stable while valid is high and not yet accepted. in_ready is high only
// in IDLE, and out_valid is high only in DONE, so an input is never
// accepted while a result is waiting.
//
// Ports:
//   CLK        clock, all state updates on posedge
//   RST        asynchronous active-low reset
//   in_valid   root is valid this cycle
//   in_ready   block can accept a root (state == IDLE)
//   root       unsigned value to square, sampled on the accept edge
//   out_valid  sq holds a finished result
//   out_ready  consumer takes sq this cycle
//   sq         root*root, unsigned; holds its value after the handshake
//   busy       state != IDLE
//   dbg_state  current FSM state (0=IDLE, 1=CALC, 2=DONE)
module square_num #(
  parameter int WIDTH = 8
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   root,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] sq,
  output logic               busy,
  output logic [1:0]         dbg_state
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplr;
  logic [2*WIDTH-1:0] acc;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] acc_next;

  // Accumulator value after the current iteration; on the last CALC
  // iteration this is the complete square, so it is stored straight into sq.
  assign acc_next = acc + (mplr[0] ? mcand : '0);

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign dbg_state = state_q;

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (in_valid) state_d = CALC;
      CALC: if (cnt == LAST) state_d = DONE;
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath registers.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      mcand     <= '0;
      mplr      <= '0;
      acc       <= '0;
      cnt       <= '0;
      sq        <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            mcand <= {{WIDTH{1'b0}}, root};
            mplr  <= root;
            acc   <= '0;
            cnt   <= '0;
          end
        end
        CALC: begin
          acc   <= acc_next;
          mcand <= mcand << 1;
          mplr  <= mplr >> 1;
          cnt   <= cnt + CW'(1);
          if (cnt == LAST) begin
            sq        <= acc_next;
            out_valid <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) out_valid <= 1'b0;
        end
        default: begin
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_square_num.sv
// Bench for square_num: directed cases plus randomized and exhaustive
// sweeps, with a scoreboard queue of expected squares and monitors that
// check results, latency, hold stability and handshake exclusivity.
module tb_square_num;

  localparam int W  = 8;
  localparam int W2 = 2 * W;

  logic          CLK;
  logic          RST;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  root;
  logic          out_valid;
  logic          out_ready;
  logic [W2-1:0] sq;
  logic          busy;
  logic [1:0]    dbg_state;

  square_num #(.WIDTH(W)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .root      (root),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sq        (sq),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_pass   = 0;

  function automatic void chk(string name, longint act, longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endfunction

  function automatic void chk_timeout(string name);
    n_checks++;
    $display("FAIL %s: timed out waiting (t=%0t)", name, $time);
  endfunction

  // ---------------- reference model ----------------
  function automatic logic [W2-1:0] ref_square(input int r);
    return W2'(r * r);
  endfunction

  // Integer square root, as the companion square-root block would compute.
  function automatic int ref_isqrt(input int v);
    int r;
    r = 0;
    while ((r + 1) * (r + 1) <= v) r++;
    return r;
  endfunction

  // ---------------- scoreboard ----------------
  logic [W2-1:0] exp_q[$];
  int            root_q[$];
  int            acc_log[$];

  bit            prev_ov = 1'b0;
  bit            prev_or = 1'b0;
  logic [W2-1:0] prev_sq = '0;
  bit            pend    = 1'b0;
  int            last_acc = 0;

  always @(negedge CLK) begin
    if (!RST) begin
      exp_q.delete();
      root_q.delete();
      pend    = 1'b0;
      prev_ov = 1'b0;
      prev_or = 1'b0;
    end else begin
      // input accept seen: the transfer happens on the next edge
      if (in_valid && in_ready) begin
        last_acc = cyc + 1;
        acc_log.push_back(cyc + 1);
        pend = 1'b1;
      end
      // first cycle of a result: latency from the accept edge
      if (out_valid && !prev_ov) begin
        if (pend) chk("latency", cyc - last_acc, W);
        pend = 1'b0;
      end
      // while a result waits without being taken it must not move
      if (prev_ov && !prev_or) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_sq", sq, prev_sq);
      end
      // no input accepted while a result is presented
      if (out_valid) chk("no_overlap_in_ready", in_ready, 0);
      // output transfer
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk_timeout("unexpected_result");
        end else begin
          logic [W2-1:0] e;
          int r;
          e = exp_q.pop_front();
          r = root_q.pop_front();
          chk("sq", sq, e);
          chk("sqrt_roundtrip", ref_isqrt(int'(sq)), r);
        end
      end
      prev_ov = out_valid;
      prev_or = out_ready;
      prev_sq = sq;
    end
  end

  // ---------------- driver ----------------
  // Called at posedge+1. Waits for in_ready, presents r for one accept
  // edge and returns at posedge+1 after it. in_valid is left high so
  // callers can run back-to-back; rnd randomizes out_ready every cycle.
  task automatic issue(input int r, input bit rnd);
    int g;
    g = 0;
    while (!in_ready && g < 300) begin
      if (rnd) out_ready = 1'($urandom_range(0, 1));
      @(posedge CLK); #1;
      g++;
    end
    if (!in_ready) begin
      chk_timeout("accept_wait");
      return;
    end
    in_valid = 1'b1;
    root     = W'(r);
    exp_q.push_back(ref_square(r));
    root_q.push_back(r);
    if (rnd) out_ready = 1'($urandom_range(0, 1));
    @(posedge CLK); #1;
  endtask

  task automatic wait_valid(input string name);
    int g;
    g = 0;
    while (!out_valid && g < 50) begin
      @(posedge CLK); #1;
      g++;
    end
    if (!out_valid) chk_timeout(name);
  endtask

  task automatic drain();
    int g;
    g = 0;
    out_ready = 1'b1;
    while (exp_q.size() != 0 && g < 100) begin
      @(posedge CLK); #1;
      g++;
    end
    if (exp_q.size() != 0) chk_timeout("drain");
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n0;
    int b2b[3];
    b2b[0] = 3; b2b[1] = 7; b2b[2] = 200;

    RST       = 1'b0;
    in_valid  = 1'b0;
    root      = '0;
    out_ready = 1'b1;

    // reset values
    #3;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_sq", sq, 0);
    chk("rst_busy", busy, 0);
    chk("rst_state", dbg_state, 0);
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b1;
    @(posedge CLK); #1;

    // root=0 with out_ready high: latency checked by the monitor
    issue(0, 1'b0);
    in_valid = 1'b0;
    chk("calc_busy", busy, 1);
    chk("calc_state", dbg_state, 1);
    drain();

    // corner roots
    issue(255, 1'b0); in_valid = 1'b0; drain();
    issue(16, 1'b0);  in_valid = 1'b0; drain();
    issue(1, 1'b0);   in_valid = 1'b0; drain();

    // back-pressure with in_valid pulses during DONE
    out_ready = 1'b0;
    issue(12, 1'b0);
    in_valid = 1'b0;
    wait_valid("bp_valid");
    n0 = acc_log.size();
    for (int i = 0; i < 5; i++) begin
      in_valid = (i % 2 == 0);
      root     = W'(77);
      @(posedge CLK); #1;
    end
    chk("bp_still_valid", out_valid, 1);
    chk("bp_sq_held", sq, 144);
    chk("bp_no_accept", acc_log.size(), n0);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge CLK); #1;
    chk("bp_valid_dropped", out_valid, 0);
    chk("bp_sq_kept", sq, 144);
    chk("bp_idle", in_ready, 1);

    // back-to-back with in_valid held high
    n0 = acc_log.size();
    for (int i = 0; i < 3; i++) issue(b2b[i], 1'b0);
    in_valid = 1'b0;
    drain();
    if (acc_log.size() == n0 + 3) begin
      chk("b2b_spacing_1", acc_log[n0+1] - acc_log[n0], W + 2);
      chk("b2b_spacing_2", acc_log[n0+2] - acc_log[n0+1], W + 2);
    end else begin
      chk("b2b_accept_count", acc_log.size() - n0, 3);
    end

    // reset in the fourth CALC cycle of root=99
    issue(99, 1'b0);
    in_valid = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    chk("mid_calc_state", dbg_state, 1);
    #1;
    RST = 1'b0;
    #1;
    chk("abort_out_valid", out_valid, 0);
    chk("abort_sq", sq, 0);
    chk("abort_state", dbg_state, 0);
    chk("abort_in_ready", in_ready, 1);
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b1;
    @(posedge CLK); #1;
    issue(5, 1'b0); in_valid = 1'b0; drain();

    // randomized roots with random back-pressure
    for (int i = 0; i < 60; i++) begin
      issue(int'($urandom_range(0, 255)), 1'b1);
      in_valid = 1'b0;
    end
    drain();

    // exhaustive sweep
    for (int r = 0; r < 256; r++) begin
      issue(r, 1'b0);
      in_valid = 1'b0;
    end
    drain();

    repeat (3) @(posedge CLK);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
